// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I
// funct3 encodings, request legality check and the store-merge function.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RMW_READ = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP     = 3'd4
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Illegal funct3 for the direction, or a misaligned halfword/word access.
  function automatic logic access_error(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] off);
    logic legal;
    if (is_store) legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else          legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                          (funct3 == F3_BU) || (funct3 == F3_HU);
    return !legal ||
           ((funct3[1:0] == 2'b01) && off[0]) ||
           ((funct3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  // Replace the addressed lane of a RAM word with right-aligned store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  off);
    logic [31:0] res;
    res = word;
    case (funct3)
      F3_B: res[{off, 3'b000} +: 8] = data[7:0];
      F3_H: begin
        if (off[1]) res[31:16] = data[15:0];
        else        res[15:0]  = data[15:0];
      end
      F3_W:    res = data;
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane select with sign/zero extension.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Bring the addressed byte/halfword down to bit 0 (off is 0 for words).
  assign shifted = word >> {off, 3'b000};

  // Extend the selected lane according to the load type.
  always_comb begin
    result = 32'h0;
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    result = shifted;
      F3_BU:   result = {24'h0, shifted[7:0]};
      F3_HU:   result = {16'h0, shifted[15:0]};
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-addressed, combinational-read RAM.
// Sub-word stores are read-modify-write. Handshake: a request transfers on a
// rising edge where req_valid && req_ready; req_ready is high only in IDLE.
// resp_valid is a one-cycle pulse with no back-pressure.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_store_data,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_load_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [2:0]            state_dbg
);

  lsu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] widx_q;
  logic [1:0]            off_q;
  logic [2:0]            funct3_q;
  logic [31:0]           store_data_q;
  logic [31:0]           merge_q;
  logic                  err_q;
  logic [31:0]           load_q;
  logic [31:0]           align_out;
  logic                  req_err;
  logic                  unused_addr_bits;

  // Upper address bits wrap modulo the RAM size.
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  assign req_err = access_error(req_is_store, req_funct3, req_addr[1:0]);

  lsu_load_align u_align (
    .word   (mem_read_data),
    .funct3 (funct3_q),
    .off    (off_q),
    .result (align_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_err)                 state_d = ST_RESP;
          else if (!req_is_store)      state_d = ST_LOAD;
          else if (req_funct3 == F3_W) state_d = ST_WRITE;
          else                         state_d = ST_RMW_READ;
        end
      end
      ST_LOAD:     state_d = ST_RESP;
      ST_RMW_READ: state_d = ST_WRITE;
      ST_WRITE:    state_d = ST_RESP;
      ST_RESP:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Request latch, load capture and store merge.
  always_ff @(posedge clk) begin
    if (rst) begin
      widx_q       <= '0;
      off_q        <= '0;
      funct3_q     <= '0;
      store_data_q <= '0;
      merge_q      <= '0;
      err_q        <= 1'b0;
      load_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            widx_q       <= req_addr[ADDR_WIDTH+1:2];
            off_q        <= req_addr[1:0];
            funct3_q     <= req_funct3;
            store_data_q <= req_store_data;
            merge_q      <= req_store_data;
            err_q        <= req_err;
            load_q       <= '0;
          end
        end
        ST_LOAD:     load_q  <= align_out;
        ST_RMW_READ: merge_q <= store_merge(mem_read_data, store_data_q, funct3_q, off_q);
        default: ;
      endcase
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign resp_valid     = (state_q == ST_RESP);
  assign resp_err       = (state_q == ST_RESP) && err_q;
  assign resp_load_data = load_q;
  assign mem_addr       = widx_q;
  // A reset arriving during WRITE must not let the write land.
  assign mem_we         = (state_q == ST_WRITE) && !rst;
  assign mem_write_data = merge_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word RAM.
module tb_load_store_unit;

  logic        clk, rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_store_data;
  logic        resp_valid, resp_err;
  logic [31:0] resp_load_data;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_write_data, mem_read_data;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  load_store_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_store_data(req_store_data),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_load_data(resp_load_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .state_dbg(state_dbg)
  );

  // ---------------- clock / RAM model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [0:1023];
  logic        ram_clear, preload_en;
  logic [9:0]  preload_idx;
  logic [31:0] preload_val;

  assign mem_read_data = ram[mem_addr];

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
    end else if (preload_en) begin
      ram[preload_idx] <= preload_val;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_write_data;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] val);
    @(negedge clk);
    preload_en  = 1'b1;
    preload_idx = idx;
    preload_val = val;
    @(posedge clk);
    #1 preload_en = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Issue one request and watch cycles 1..8 after the handshake edge.
  task automatic do_op(input logic is_store, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       output int lat, output int we_cyc, output int we_cnt,
                       output logic err, output logic [31:0] data,
                       output logic [9:0] maddr);
    lat = -1; we_cyc = -1; we_cnt = 0; err = 1'bx; data = 'x; maddr = 'x;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = is_store; req_funct3 = f3;
    req_addr = addr; req_store_data = sdata;
    chk("ready_before_req", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (mem_we) begin
        we_cnt++;
        we_cyc = k;
      end
      if (resp_valid) begin
        lat = k; err = resp_err; data = resp_load_data; maddr = mem_addr;
        break;
      end
    end
  endtask

  typedef struct {
    logic        pre;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        e_err;
    logic [31:0] e_data;
    int          e_lat;
    int          e_we_cyc;
    int          e_we_cnt;
    logic [9:0]  idx;
    logic [31:0] e_word;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  logic [32:0] exp_q [$];

  initial begin
    int          lat, we_cyc, we_cnt, acc, resp_seen;
    logic        err;
    logic [31:0] data;
    logic [9:0]  maddr;
    logic [32:0] got;
    logic        acc_now;
    int          idx;
    vec_t        ops [4];

    //            pre st f3      addr        sdata         err data          lat we  cnt idx word
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h5,    32'h0,        1'b0, 32'hFFFFFFAA, 2, -1, 0, 10'd1, 32'h8899AABB};
    vecs[1]  = '{1'b0, 1'b0, 3'b100, 32'h5,    32'h0,        1'b0, 32'h000000AA, 2, -1, 0, 10'd1, 32'h8899AABB};
    vecs[2]  = '{1'b0, 1'b0, 3'b101, 32'h6,    32'h0,        1'b0, 32'h00008899, 2, -1, 0, 10'd1, 32'h8899AABB};
    vecs[3]  = '{1'b0, 1'b0, 3'b001, 32'h6,    32'h0,        1'b0, 32'hFFFF8899, 2, -1, 0, 10'd1, 32'h8899AABB};
    vecs[4]  = '{1'b0, 1'b1, 3'b000, 32'h7,    32'h00000011, 1'b0, 32'h0,        3,  2, 1, 10'd1, 32'h1199AABB};
    vecs[5]  = '{1'b0, 1'b0, 3'b010, 32'h4,    32'h0,        1'b0, 32'h1199AABB, 2, -1, 0, 10'd1, 32'h1199AABB};
    vecs[6]  = '{1'b1, 1'b1, 3'b001, 32'h4,    32'hDEADBEEF, 1'b0, 32'h0,        3,  2, 1, 10'd1, 32'h8899BEEF};
    vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h4,    32'h12345678, 1'b0, 32'h0,        2,  1, 1, 10'd1, 32'h12345678};
    vecs[8]  = '{1'b0, 1'b0, 3'b010, 32'h6,    32'h0,        1'b1, 32'h0,        1, -1, 0, 10'd1, 32'h12345678};
    vecs[9]  = '{1'b0, 1'b0, 3'b001, 32'h5,    32'h0,        1'b1, 32'h0,        1, -1, 0, 10'd1, 32'h12345678};
    vecs[10] = '{1'b0, 1'b1, 3'b010, 32'h2,    32'hCAFEF00D, 1'b1, 32'h0,        1, -1, 0, 10'd0, 32'h00000000};
    vecs[11] = '{1'b0, 1'b0, 3'b011, 32'h4,    32'h0,        1'b1, 32'h0,        1, -1, 0, 10'd1, 32'h12345678};
    vecs[12] = '{1'b0, 1'b1, 3'b100, 32'h4,    32'hFFFFFFFF, 1'b1, 32'h0,        1, -1, 0, 10'd1, 32'h12345678};
    vecs[13] = '{1'b0, 1'b0, 3'b010, 32'h1004, 32'h0,        1'b0, 32'h12345678, 2, -1, 0, 10'd1, 32'h12345678};
    vecs[14] = '{1'b0, 1'b1, 3'b000, 32'h8,    32'h1234567F, 1'b0, 32'h0,        3,  2, 1, 10'd2, 32'h0000007F};
    vecs[15] = '{1'b0, 1'b1, 3'b001, 32'hA,    32'h0000CAFE, 1'b0, 32'h0,        3,  2, 1, 10'd2, 32'hCAFE007F};
    vecs[16] = '{1'b0, 1'b0, 3'b001, 32'hA,    32'h0,        1'b0, 32'hFFFFCAFE, 2, -1, 0, 10'd2, 32'hCAFE007F};
    vecs[17] = '{1'b0, 1'b0, 3'b000, 32'hB,    32'h0,        1'b0, 32'hFFFFFFCA, 2, -1, 0, 10'd2, 32'hCAFE007F};
    vecs[18] = '{1'b0, 1'b0, 3'b100, 32'h9,    32'h0,        1'b0, 32'h00000000, 2, -1, 0, 10'd2, 32'hCAFE007F};
    vecs[19] = '{1'b0, 1'b0, 3'b000, 32'h8,    32'h0,        1'b0, 32'h0000007F, 2, -1, 0, 10'd2, 32'hCAFE007F};

    // ---- reset ----
    rst = 1'b1; ram_clear = 1'b1; preload_en = 1'b0; preload_idx = '0; preload_val = '0;
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0; req_addr = '0; req_store_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; ram_clear = 1'b0;
    #1;
    chk("rst_req_ready",      {31'h0, req_ready},  32'h1);
    chk("rst_resp_valid",     {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err",       {31'h0, resp_err},   32'h0);
    chk("rst_resp_load_data", resp_load_data,      32'h0);
    chk("rst_mem_addr",       {22'h0, mem_addr},   32'h0);
    chk("rst_mem_we",         {31'h0, mem_we},     32'h0);
    chk("rst_mem_write_data", mem_write_data,      32'h0);

    // ---- table-driven single operations ----
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].pre) preload(10'd1, 32'h8899AABB);
      do_op(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].sdata, lat, we_cyc, we_cnt, err, data, maddr);
      chk($sformatf("v%0d_latency", i),  lat,                vecs[i].e_lat);
      chk($sformatf("v%0d_we_count", i), we_cnt,             vecs[i].e_we_cnt);
      chk($sformatf("v%0d_we_cycle", i), we_cyc,             vecs[i].e_we_cyc);
      chk($sformatf("v%0d_err", i),      {31'h0, err},       {31'h0, vecs[i].e_err});
      chk($sformatf("v%0d_data", i),     data,               vecs[i].e_data);
      chk($sformatf("v%0d_mem_addr", i), {22'h0, maddr},     {22'h0, vecs[i].addr[11:2]});
      chk($sformatf("v%0d_ram_word", i), ram[vecs[i].idx],   vecs[i].e_word);
    end

    // ---- reset during the WRITE cycle of an SB (word 2 = CAFE007F) ----
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h8; req_store_data = 32'h00000055;
    @(posedge clk);
    @(negedge clk);                       // cycle 1: RMW_READ
    req_valid = 1'b0;
    chk("rstw_we_in_rmw", {31'h0, mem_we}, 32'h0);
    @(negedge clk);                       // cycle 2: WRITE
    chk("rstw_state_write", {29'h0, state_dbg}, 32'h3);
    rst = 1'b1;
    #1;
    chk("rstw_we_gated", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstw_ready_after", {31'h0, req_ready}, 32'h1);
    resp_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) resp_seen++;
      @(negedge clk);
    end
    chk("rstw_no_resp", resp_seen, 0);
    chk("rstw_ram_kept", ram[2], 32'hCAFE007F);

    // ---- back-to-back with req_valid held high ----
    ops[0] = '{1'b0, 1'b1, 3'b010, 32'hC,  32'hA1A1A1A1, 1'b0, 32'h0,        0, 0, 0, 10'd3, 32'hA1A1A1A1};
    ops[1] = '{1'b0, 1'b0, 3'b010, 32'hC,  32'h0,        1'b0, 32'hA1A1A1A1, 0, 0, 0, 10'd3, 32'hA1A1A1A1};
    ops[2] = '{1'b0, 1'b1, 3'b000, 32'h10, 32'h000000B2, 1'b0, 32'h0,        0, 0, 0, 10'd4, 32'h000000B2};
    ops[3] = '{1'b0, 1'b0, 3'b000, 32'h10, 32'h0,        1'b0, 32'hFFFFFFB2, 0, 0, 0, 10'd4, 32'h000000B2};
    idx = 0; acc = 0; resp_seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = ops[0].st; req_funct3 = ops[0].f3;
    req_addr = ops[0].addr; req_store_data = ops[0].sdata;
    for (int c = 0; c < 40 && (idx < 4 || exp_q.size() > 0); c++) begin
      if (c > 0) @(negedge clk);
      acc_now = 1'b0;
      if (resp_valid) begin
        resp_seen++;
        if (exp_q.size() == 0) begin
          chk("b2b_unexpected_resp", {31'h0, resp_valid}, 32'h0);
        end else begin
          got = exp_q.pop_front();
          chk($sformatf("b2b_resp%0d", resp_seen), {resp_err, resp_load_data}, got);
        end
      end
      if (req_valid && req_ready) begin
        exp_q.push_back({ops[idx].e_err, ops[idx].e_data});
        acc++;
        acc_now = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        idx++;
        if (idx < 4) begin
          req_is_store = ops[idx].st; req_funct3 = ops[idx].f3;
          req_addr = ops[idx].addr; req_store_data = ops[idx].sdata;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepted",  acc,       4);
    chk("b2b_responses", resp_seen, 4);
    chk("b2b_word3",     ram[3],    32'hA1A1A1A1);
    chk("b2b_word4",     ram[4],    32'h000000B2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for the word-wide data RAM. It accepts one RV32I load or store per handshake and drives the RAM's address, write-enable and write-data ports, which are word-addressed, single-write-enable and combinational-read. Byte and halfword stores become a read-modify-write sequence. Loads are extracted and sign- or zero-extended into a 32-bit result returned to the memory stage.

## Interface
- ADDR_WIDTH, 10: RAM word-address width; must match the RAM instance.
- DATA_WIDTH, 32: word width; only 32 is supported.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- req_addr  in  32  byte address.
- req_store_data  in  32  store source, right-aligned.
- resp_valid  out  1  one-cycle completion pulse; no back-pressure.
- resp_err  out  1  valid with resp_valid; misaligned access or illegal funct3.
- resp_load_data  out  32  extended load result; 0 for stores and errors.
- mem_addr  out  ADDR_WIDTH  RAM word index, equal to latched addr[ADDR_WIDTH+1:2].
- mem_we  out  1  RAM write enable.
- mem_write_data  out  32  RAM write word.
- mem_read_data  in  32  RAM combinational read of mem_addr.

## Operation
- A handshake occurs when req_valid and req_ready are both high at a rising edge. On that edge the unit latches addr, funct3, is_store and store_data.
- Address bits above ADDR_WIDTH+1 are ignored; the access wraps modulo the RAM size.
- Error conditions: funct3 not in the legal set for the direction; halfword with addr[0]=1; word with addr[1:0]≠0.
- FSM states and transitions:
  - IDLE: on handshake, go to RESP if the request is an error. Otherwise loads go to LOAD, SW goes to WRITE (merge register = store_data), SB/SH go to RMW_READ.
  - LOAD: capture mem_read_data, select the lane by addr[1:0], extend per funct3, then go to RESP.
  - RMW_READ: merge register = mem_read_data with the lane bytes replaced (SB: byte addr[1:0]; SH: halfword addr[1]), then go to WRITE.
  - WRITE: mem_we=1 and mem_write_data=merge register, then go to RESP.
  - RESP: resp_valid=1, then go to IDLE.
- mem_we = (state==WRITE) && !rst. A reset asserted while in WRITE suppresses the write.
- Reset mid-operation abandons the access entirely: no response and no write.
- Reset values: state IDLE, resp_valid 0, resp_err 0, resp_load_data 0, mem_addr 0, mem_we 0, mem_write_data 0.
- req_ready is decoded from state and is 1 in the first cycle after reset.

## Timing
- Cycle 0 is the handshake edge. The response pulse appears in:
  - Load: cycle 2 (LOAD at 1, RESP at 2).
  - SW: cycle 2; mem_we high during cycle 1 only.
  - SB/SH: cycle 3; RMW_READ at 1, mem_we high during cycle 2 only.
  - Error: cycle 1; mem_we never asserted.
- The next handshake is possible on the edge that ends RESP.
- mem_addr is stable from cycle 1 until returning to IDLE.
- The RAM write lands on the edge ending WRITE. A load issued afterward observes it.

## Structure
- Package lsu_pkg holds:
  - the state enum;
  - funct3 localparams;
  - a store_merge function (word, data, funct3, byte offset -> word).
- Sub-module lsu_load_align: combinational lane select plus sign/zero extension (word, funct3, addr[1:0] -> 32-bit result). It is unit-testable on its own.

## Test plan
- Preload word 1 = 0x8899AABB; LB 0x5 -> resp at cycle 2, data 0xFFFFFFAA; LBU 0x5 -> 0x000000AA; LHU 0x6 -> 0x00008899; LH 0x6 -> 0xFFFF8899.
- SB 0x7, data 0x00000011 -> mem_we only in cycle 2, written word 0x1199AABB; a following LW 0x4 returns 0x1199AABB.
- SH 0x4, data 0xDEADBEEF -> word 0x8899BEEF. SW 0x4, data 0x12345678 -> mem_we in cycle 1, word 0x12345678.
- LW 0x6, LH 0x5, SW 0x2 and funct3 011 -> resp_err=1 at cycle 1, resp_load_data 0, mem_we never high, RAM unchanged.
- Assert rst during WRITE of an SB -> no mem_we, RAM unchanged, no resp_valid, req_ready=1 the next cycle.
- Hold req_valid continuously with four alternating SW/LW ops -> each accepted exactly when req_ready=1, with one resp_valid pulse per op in order.
